// File: rtl/pixel_motion_pkg.sv
// Shared types for the pixel motion controller: FSM states and key bit positions.
package pixel_motion_pkg;

  typedef enum logic [1:0] {IDLE, DELAY, REPEAT} state_t;

  localparam int UP    = 3;
  localparam int DOWN  = 2;
  localparam int LEFT  = 1;
  localparam int RIGHT = 0;

endpackage

// File: rtl/pixel_motion_controller_key_sync.sv
// Two-flop synchroniser for the raw buttons plus a one-cycle delayed copy
// so the controller can see when the held combination changes.
module key_sync (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] key,
  output logic [3:0] key_s,
  output logic       key_chg
);

  logic [3:0] meta_q, sync_q, dly_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      meta_q <= '0;
      sync_q <= '0;
      dly_q  <= '0;
    end else begin
      meta_q <= key;
      sync_q <= meta_q;
      dly_q  <= sync_q;
    end
  end

  assign key_s   = sync_q;
  assign key_chg = (sync_q != dly_q);

endmodule

// File: rtl/pixel_motion_controller.sv
// Push-button driven object positioner: step on press, auto-repeat on hold,
// independent row/col axes with clamping to the visible area.
module pixel_motion_controller
  import pixel_motion_pkg::*;
#(
  parameter int COORD_W       = 11,
  parameter int H_RES         = 640,
  parameter int V_RES         = 480,
  parameter int OBJ_W         = 16,
  parameter int OBJ_H         = 16,
  parameter int STEP          = 4,
  parameter int HOLD_CYCLES   = 2**20,
  parameter int REPEAT_CYCLES = 2**18,
  parameter int INIT_ROW      = 232,
  parameter int INIT_COL      = 312
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [3:0]         key,
  output logic [COORD_W-1:0] obj_row,
  output logic [COORD_W-1:0] obj_col,
  output logic               moving,
  output logic [3:0]         at_edge
);

  localparam int ROW_MAX = V_RES - OBJ_H;
  localparam int COL_MAX = H_RES - OBJ_W;
  localparam int CNT_MAX = (HOLD_CYCLES > REPEAT_CYCLES) ? HOLD_CYCLES : REPEAT_CYCLES;
  localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;

  localparam logic [CNT_W-1:0]   HOLD_TC   = CNT_W'(HOLD_CYCLES - 1);
  localparam logic [CNT_W-1:0]   REPEAT_TC = CNT_W'(REPEAT_CYCLES - 1);
  localparam logic [COORD_W:0]   STEP_X    = (COORD_W+1)'(STEP);
  localparam logic [COORD_W:0]   ROW_LIM   = (COORD_W+1)'(ROW_MAX);
  localparam logic [COORD_W:0]   COL_LIM   = (COORD_W+1)'(COL_MAX);
  localparam logic [COORD_W-1:0] ROW_MAX_C = COORD_W'(ROW_MAX);
  localparam logic [COORD_W-1:0] COL_MAX_C = COORD_W'(COL_MAX);
  localparam logic [3:0] AT_EDGE_INIT = {INIT_ROW == 0, INIT_ROW == ROW_MAX,
                                         INIT_COL == 0, INIT_COL == COL_MAX};

  if (OBJ_W < 1 || OBJ_W > H_RES || OBJ_H < 1 || OBJ_H > V_RES) begin : g_bad_obj
    $fatal(1, "pixel_motion_controller: object size out of range");
  end
  if (STEP < 1 || STEP >= 2**COORD_W) begin : g_bad_step
    $fatal(1, "pixel_motion_controller: STEP out of range");
  end
  if (INIT_ROW < 0 || INIT_ROW > ROW_MAX || INIT_COL < 0 || INIT_COL > COL_MAX ||
      ROW_MAX >= 2**COORD_W || COL_MAX >= 2**COORD_W) begin : g_bad_init
    $fatal(1, "pixel_motion_controller: INIT position or bounds out of range");
  end
  if (HOLD_CYCLES < 1 || REPEAT_CYCLES < 1) begin : g_bad_timing
    $fatal(1, "pixel_motion_controller: hold/repeat cycles must be >= 1");
  end

  logic [3:0] key_s;
  logic       key_chg;

  key_sync u_key_sync (
    .clk     (clk),
    .rst     (rst),
    .key     (key),
    .key_s   (key_s),
    .key_chg (key_chg)
  );

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [COORD_W-1:0] row_q, row_d, col_q, col_d;
  logic               moving_q, moving_d;
  logic [3:0]         at_edge_q, at_edge_d;
  logic               step_en;
  logic               v_dec, v_inc, h_dec, h_inc;

  // Widened by one bit so neither the decrement nor the increment can wrap.
  function automatic logic [COORD_W-1:0] axis_next(input logic [COORD_W-1:0] pos,
                                                   input logic dec, input logic inc,
                                                   input logic [COORD_W:0] lim);
    logic [COORD_W:0] p;
    p = {1'b0, pos};
    axis_next = pos;
    if (dec)
      axis_next = (p < STEP_X) ? '0 : COORD_W'(p - STEP_X);
    else if (inc)
      axis_next = ((p + STEP_X) > lim) ? COORD_W'(lim) : COORD_W'(p + STEP_X);
  endfunction

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    step_en = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (key_s != '0) begin
          step_en = 1'b1;
          cnt_d   = '0;
          state_d = DELAY;
        end
      end
      DELAY, REPEAT: begin
        if (key_s == '0) begin
          cnt_d   = '0;
          state_d = IDLE;
        end else if (key_chg) begin
          step_en = 1'b1;
          cnt_d   = '0;
          state_d = DELAY;
        end else if (cnt_q == ((state_q == DELAY) ? HOLD_TC : REPEAT_TC)) begin
          step_en = 1'b1;
          cnt_d   = '0;
          state_d = REPEAT;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: begin
        cnt_d   = '0;
        state_d = IDLE;
      end
    endcase
  end

  // Opposing keys on one axis cancel; the other axis still moves.
  always_comb begin
    v_dec     = step_en & key_s[UP]    & ~key_s[DOWN];
    v_inc     = step_en & key_s[DOWN]  & ~key_s[UP];
    h_dec     = step_en & key_s[LEFT]  & ~key_s[RIGHT];
    h_inc     = step_en & key_s[RIGHT] & ~key_s[LEFT];
    row_d     = axis_next(row_q, v_dec, v_inc, ROW_LIM);
    col_d     = axis_next(col_q, h_dec, h_inc, COL_LIM);
    moving_d  = (state_d != IDLE);
    at_edge_d = {row_d == '0, row_d == ROW_MAX_C, col_d == '0, col_d == COL_MAX_C};
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      row_q     <= COORD_W'(INIT_ROW);
      col_q     <= COORD_W'(INIT_COL);
      moving_q  <= 1'b0;
      at_edge_q <= AT_EDGE_INIT;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      row_q     <= row_d;
      col_q     <= col_d;
      moving_q  <= moving_d;
      at_edge_q <= at_edge_d;
    end
  end

  assign obj_row = row_q;
  assign obj_col = col_q;
  assign moving  = moving_q;
  assign at_edge = at_edge_q;

endmodule

// File: tb/tb_pixel_motion_controller.sv
// Bench for pixel_motion_controller: directed scenarios plus random key holds,
// compared every cycle against a run-length based reference model.
module tb_pixel_motion_controller;

  localparam int CW   = 11;
  localparam int S    = 4;
  localparam int H    = 8;
  localparam int R    = 4;
  localparam int RMAX = 480 - 16;
  localparam int CMAX = 640 - 16;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic [3:0]    key = '0, key2 = '0;
  logic [CW-1:0] obj_row, obj_col, row2, col2;
  logic          moving, moving2;
  logic [3:0]    at_edge, at_edge2;

  int   pass_cnt = 0, total_cnt = 0;
  int   m_row, m_col, run_len;
  logic [3:0] p0, p1, prev_ks;
  logic m_mov;

  always #5 clk = ~clk;

  pixel_motion_controller #(.STEP(S), .HOLD_CYCLES(H), .REPEAT_CYCLES(R)) u_dut (
    .clk(clk), .rst(rst), .key(key),
    .obj_row(obj_row), .obj_col(obj_col), .moving(moving), .at_edge(at_edge)
  );

  pixel_motion_controller #(.STEP(S), .HOLD_CYCLES(H), .REPEAT_CYCLES(R),
                            .INIT_ROW(2), .INIT_COL(6)) u_dut2 (
    .clk(clk), .rst(rst), .key(key2),
    .obj_row(row2), .obj_col(col2), .moving(moving2), .at_edge(at_edge2)
  );

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    assert (act === exp) pass_cnt++;
    else $error("FAIL %s: got %0d expected %0d", tag, act, exp);
  endtask

  function automatic int clampi(input int v, input int hi);
    return (v < 0) ? 0 : ((v > hi) ? hi : v);
  endfunction

  task automatic model_reset();
    m_row = 232; m_col = 312;
    p0 = '0; p1 = '0; prev_ks = '0;
    run_len = 0; m_mov = 1'b0;
  endtask

  // A step happens on the first cycle a nonzero combination is seen, then
  // after H further cycles, then every R cycles, as long as it is unchanged.
  task automatic model_edge(input logic [3:0] k);
    logic [3:0] ks;
    logic       step;
    ks      = p1;
    run_len = (ks == prev_ks) ? run_len + 1 : 1;
    prev_ks = ks;
    step = (ks != 0) && (run_len == 1 || (run_len - 1 >= H && (run_len - 1 - H) % R == 0));
    if (step) begin
      if (ks[3] && !ks[2])      m_row = clampi(m_row - S, RMAX);
      else if (ks[2] && !ks[3]) m_row = clampi(m_row + S, RMAX);
      if (ks[1] && !ks[0])      m_col = clampi(m_col - S, CMAX);
      else if (ks[0] && !ks[1]) m_col = clampi(m_col + S, CMAX);
    end
    m_mov = (ks != 0);
    p1 = p0;
    p0 = k;
  endtask

  task automatic check_all(input string tag);
    chk({tag, ".row"},  obj_row, m_row);
    chk({tag, ".col"},  obj_col, m_col);
    chk({tag, ".mov"},  moving,  m_mov);
    chk({tag, ".edge"}, at_edge, {m_row == 0, m_row == RMAX, m_col == 0, m_col == CMAX});
  endtask

  task automatic cyc(input logic [3:0] k, input string tag);
    key = k;
    @(posedge clk);
    model_edge(k);
    @(negedge clk);
    check_all(tag);
  endtask

  task automatic check_init(input string tag);
    chk({tag, ".row"},  obj_row, 232);
    chk({tag, ".col"},  obj_col, 312);
    chk({tag, ".mov"},  moving,  0);
    chk({tag, ".edge"}, at_edge, 0);
  endtask

  initial begin
    logic [3:0] rk;
    int         rd;

    model_reset();
    rst = 1'b0;
    repeat (3) @(negedge clk);
    check_init("reset");
    chk("reset.row2",  row2, 2);
    chk("reset.col2",  col2, 6);
    chk("reset.edge2", at_edge2, 0);
    rst = 1'b1;

    cyc(4'b0001, "tap");
    repeat (12) cyc(4'b0000, "tap");
    chk("tap.col_final", obj_col, 316);
    chk("tap.row_final", obj_row, 232);

    repeat (30) cyc(4'b1000, "hold_up");
    repeat (6) cyc(4'b0000, "hold_up");
    chk("hold_up.row_final", obj_row, 204);

    repeat (6) cyc(4'b1100, "cancel");
    chk("cancel.row_final", obj_row, 204);
    chk("cancel.mov_final", moving, 1);
    repeat (3) cyc(4'b0100, "chg_down");
    chk("chg_down.row_final", obj_row, 208);

    repeat (300) cyc(4'b0100, "clamp");
    chk("clamp.row_final", obj_row, RMAX);
    chk("clamp.edge_final", at_edge[2], 1);

    // async reset while the key is still held in auto-repeat
    rst = 1'b0;
    #1;
    check_init("async_rst");
    model_reset();
    @(posedge clk);
    @(negedge clk);
    check_init("rst_held");
    rst = 1'b1;
    repeat (2) cyc(4'b0100, "rst_rel");
    chk("rst_rel.no_early_step", obj_row, 232);
    cyc(4'b0100, "rst_rel");
    chk("rst_rel.first_step", obj_row, 236);
    repeat (6) cyc(4'b0000, "rst_rel");

    repeat (40) begin
      rk = 4'($urandom_range(0, 15));
      rd = $urandom_range(1, 20);
      repeat (rd) cyc(rk, "rand");
    end
    repeat (4) cyc(4'b0000, "rand");

    // top-left corner approach on the second instance
    key2 = 4'b1010;
    for (int i = 0; i < 24; i++) begin
      cyc(4'b0000, "idle1");
      if (i == 1) chk("corner.row_pre", row2, 2);
      if (i == 2) begin
        chk("corner.row_s1", row2, 0);
        chk("corner.col_s1", col2, 2);
        chk("corner.edge_s1", at_edge2, 4'b1000);
      end
      if (i == 10) begin
        chk("corner.row_s2", row2, 0);
        chk("corner.col_s2", col2, 0);
        chk("corner.edge_s2", at_edge2, 4'b1010);
      end
    end
    chk("corner.row_hold", row2, 0);
    chk("corner.col_hold", col2, 0);
    chk("corner.edge_hold", at_edge2, 4'b1010);
    chk("corner.mov_hold", moving2, 1);
    key2 = 4'b0000;

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
